// File: rtl/std_mem_d1_stream_rd.sv
// Streaming reader for a std_mem_d1: on go, walks a contiguous (wrapping) address
// window and presents each word on a valid/ready stream, then pulses done.
module std_mem_d1_stream_rd #(
   parameter int WIDTH    = 32,
   parameter int SIZE     = 16,
   parameter int IDX_SIZE = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                go,
   input  logic [IDX_SIZE-1:0] start_addr,
   input  logic [IDX_SIZE:0]   count,
   output logic [IDX_SIZE-1:0] mem_addr0,
   input  logic [WIDTH-1:0]    mem_read_data,
   output logic [WIDTH-1:0]    out_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [IDX_SIZE-1:0] LAST_ADDR = IDX_SIZE'(SIZE - 1);
   localparam logic [IDX_SIZE:0]   SIZE_CNT  = (IDX_SIZE + 1)'(SIZE);

   state_t              state_r;
   logic [IDX_SIZE-1:0] addr_r;
   logic [IDX_SIZE:0]   remaining_r;
   logic [WIDTH-1:0]    out_data_r;
   logic                out_valid_r;
   logic                done_r;

   logic [IDX_SIZE-1:0] start_clip_s;
   logic [IDX_SIZE:0]   count_clip_s;
   logic [IDX_SIZE-1:0] next_addr_s;
   logic                load_s;

   // Clamp the request to the memory bounds and compute the wrapping successor address.
   always_comb begin
      start_clip_s = start_addr;
      count_clip_s = count;
      next_addr_s  = addr_r;
      load_s       = 1'b0;
      if ({1'b0, start_addr} >= SIZE_CNT) begin
         start_clip_s = {IDX_SIZE{1'b0}};
      end else begin
         start_clip_s = start_addr;
      end
      if (count > SIZE_CNT) begin
         count_clip_s = SIZE_CNT;
      end else begin
         count_clip_s = count;
      end
      if (addr_r == LAST_ADDR) begin
         next_addr_s = {IDX_SIZE{1'b0}};
      end else begin
         next_addr_s = addr_r + {{(IDX_SIZE-1){1'b0}}, 1'b1};
      end
      // A new word may enter the output register whenever the slot is empty or being drained.
      if ((state_r == ST_RUN) && (!out_valid_r || out_ready)) begin
         load_s = 1'b1;
      end else begin
         load_s = 1'b0;
      end
   end

   // Transfer FSM with registered stream and completion outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= ST_IDLE;
         addr_r      <= {IDX_SIZE{1'b0}};
         remaining_r <= {(IDX_SIZE+1){1'b0}};
         out_data_r  <= {WIDTH{1'b0}};
         out_valid_r <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_r <= 1'b0;
               if (go) begin
                  addr_r      <= start_clip_s;
                  remaining_r <= count_clip_s;
                  if (count_clip_s == {(IDX_SIZE+1){1'b0}}) begin
                     state_r <= ST_DONE;
                     done_r  <= 1'b1;
                  end else begin
                     state_r <= ST_RUN;
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_RUN: begin
               if (load_s) begin
                  out_data_r  <= mem_read_data;
                  out_valid_r <= 1'b1;
                  addr_r      <= next_addr_s;
                  remaining_r <= remaining_r - {{IDX_SIZE{1'b0}}, 1'b1};
                  // The last word is now held; only its acceptance remains.
                  if (remaining_r == {{IDX_SIZE{1'b0}}, 1'b1}) begin
                     state_r <= ST_FLUSH;
                  end else begin
                     state_r <= ST_RUN;
                  end
               end else begin
                  state_r <= ST_RUN;
               end
            end
            ST_FLUSH: begin
               if (out_ready) begin
                  out_valid_r <= 1'b0;
                  state_r     <= ST_DONE;
                  done_r      <= 1'b1;
               end else begin
                  state_r <= ST_FLUSH;
               end
            end
            ST_DONE: begin
               done_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               state_r     <= ST_IDLE;
               out_valid_r <= 1'b0;
               done_r      <= 1'b0;
            end
         endcase
      end
   end

   assign mem_addr0 = addr_r;
   assign out_data  = out_data_r;
   assign out_valid = out_valid_r;
   assign done      = done_r;

endmodule

// File: tb/tb_std_mem_d1_stream_rd.sv
// Directed bench for std_mem_d1_stream_rd against a memory holding mem[i] = 0x100 + i.
module tb_std_mem_d1_stream_rd;

   logic        clk;
   logic        reset_n;
   logic        go;
   logic [3:0]  start_addr;
   logic [4:0]  count;
   logic [3:0]  mem_addr0;
   logic [31:0] mem_read_data;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        done;

   int n_cmp = 0;
   int n_err = 0;

   std_mem_d1_stream_rd #(.WIDTH(32), .SIZE(16), .IDX_SIZE(4)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .go           (go),
      .start_addr   (start_addr),
      .count        (count),
      .mem_addr0    (mem_addr0),
      .mem_read_data(mem_read_data),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .done         (done)
   );

   assign mem_read_data = 32'h100 + {28'd0, mem_addr0};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] word_at(input int sa, input int i);
      return 32'h100 + 32'((sa + i) % 16);
   endfunction

   // Full-rate transfer: go in cycle 0, words in cycles 2..en+1, done in cycle en+2.
   task automatic xfer(input int sa, input int cnt, input int en);
      go = 1'b1; start_addr = 4'(sa); count = 5'(cnt); out_ready = 1'b1;
      chk("go_cycle_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      go = 1'b0; start_addr = 4'd9; count = 5'd2;
      if (en == 0) begin
         chk("cnt0_done", {31'd0, done}, 32'd1);
         chk("cnt0_valid", {31'd0, out_valid}, 32'd0);
      end else begin
         chk("run_valid", {31'd0, out_valid}, 32'd0);
         chk("run_done", {31'd0, done}, 32'd0);
         for (int i = 0; i < en; i++) begin
            @(negedge clk);
            chk("word_valid", {31'd0, out_valid}, 32'd1);
            chk("word_data", out_data, word_at(sa, i));
            chk("word_addr", {28'd0, mem_addr0}, 32'((sa + i + 1) % 16));
            chk("word_done", {31'd0, done}, 32'd0);
         end
         @(negedge clk);
         chk("done_pulse", {31'd0, done}, 32'd1);
         chk("done_valid", {31'd0, out_valid}, 32'd0);
      end
      @(negedge clk);
      chk("done_clear", {31'd0, done}, 32'd0);
      chk("idle_valid", {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      int sa, cnt, n, got, dones;
      logic prev_stall;
      logic [31:0] prev_data;

      reset_n = 1'b0; go = 1'b0; start_addr = 4'd0; count = 5'd0; out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_data", out_data, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_addr", {28'd0, mem_addr0}, 32'd0);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("idle_hold_valid", {31'd0, out_valid}, 32'd0);
         chk("idle_hold_done", {31'd0, done}, 32'd0);
         chk("idle_hold_addr", {28'd0, mem_addr0}, 32'd0);
      end

      // Basic window, wrap-around, zero count, oversize count.
      xfer(3, 4, 4);
      xfer(14, 4, 4);
      xfer(4, 0, 0);
      xfer(5, 20, 16);

      // Backpressure: five stalled cycles on the first word.
      go = 1'b1; start_addr = 4'd0; count = 5'd3; out_ready = 1'b0;
      @(negedge clk);
      go = 1'b0;
      chk("bp_run_valid", {31'd0, out_valid}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_stall_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_stall_data", out_data, 32'h100);
         chk("bp_stall_addr", {28'd0, mem_addr0}, 32'd1);
         chk("bp_stall_done", {31'd0, done}, 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_w1", out_data, 32'h101);
      chk("bp_w1_addr", {28'd0, mem_addr0}, 32'd2);
      @(negedge clk);
      chk("bp_w2", out_data, 32'h102);
      chk("bp_w2_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_w2_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      chk("bp_done", {31'd0, done}, 32'd1);
      chk("bp_done_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      chk("bp_done_once", {31'd0, done}, 32'd0);

      // Asynchronous reset in the middle of a stream.
      go = 1'b1; start_addr = 4'd2; count = 5'd6; out_ready = 1'b1;
      @(negedge clk);
      go = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("mr_pre_data", out_data, 32'h103);
      chk("mr_pre_valid", {31'd0, out_valid}, 32'd1);
      reset_n = 1'b0;
      #1;
      chk("mr_async_valid", {31'd0, out_valid}, 32'd0);
      chk("mr_async_data", out_data, 32'd0);
      chk("mr_async_addr", {28'd0, mem_addr0}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      chk("mr_hold_done", {31'd0, done}, 32'd0);
      reset_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("mr_idle_valid", {31'd0, out_valid}, 32'd0);
         chk("mr_idle_done", {31'd0, done}, 32'd0);
      end
      xfer(7, 2, 2);

      // Random windows under random backpressure, checked against the expected word order.
      for (int t = 0; t < 8; t++) begin
         sa  = int'($urandom_range(0, 15));
         cnt = int'($urandom_range(0, 20));
         n   = (cnt > 16) ? 16 : cnt;
         go = 1'b1; start_addr = 4'(sa); count = 5'(cnt);
         @(negedge clk);
         go = 1'b0; start_addr = 4'(sa + 5); count = 5'(cnt + 3);
         got = 0; dones = 0; prev_stall = 1'b0; prev_data = 32'd0;
         for (int c = 0; c < 300 && dones == 0; c++) begin
            if (prev_stall) begin
               chk("rnd_stall_valid", {31'd0, out_valid}, 32'd1);
               chk("rnd_stall_data", out_data, prev_data);
            end
            if (done === 1'b1) dones++;
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
               chk("rnd_word", out_data, word_at(sa, got));
               got++;
            end
            prev_stall = (out_valid === 1'b1) && !out_ready;
            prev_data  = out_data;
            @(negedge clk);
         end
         chk("rnd_count", 32'(got), 32'(n));
         chk("rnd_done_seen", 32'(dones), 32'd1);
         chk("rnd_done_clear", {31'd0, done}, 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/std_mem_d1_stream_rd.md
STD_MEM_D1_STREAM_RD -- requirements
Module: std_mem_d1_stream_rd

Purpose: go/done-driven initiator that reads a contiguous window of an attached std_mem_d1 and emits the words as a valid/ready stream.

Interface
REQ-001 Parameter WIDTH, default 32: data word width in bits; matches the attached std_mem_d1 WIDTH.
REQ-002 Parameter SIZE, default 16: number of words in the attached memory.
REQ-003 Parameter IDX_SIZE, default 4: address width in bits; requires SIZE <= 2**IDX_SIZE.
REQ-004 Port clk, input, 1: single clock; all state updates occur on its rising edge.
REQ-005 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 Port go, input, 1: start request, sampled only in IDLE.
REQ-007 Port start_addr, input, IDX_SIZE: first word address, sampled with go.
REQ-008 Port count, input, IDX_SIZE+1: number of words to transfer, sampled with go.
REQ-009 Port mem_addr0, output, IDX_SIZE: address to the memory addr0 port.
REQ-010 Port mem_read_data, input, WIDTH: combinational read data from the memory.
REQ-011 Port out_data, output, WIDTH: stream payload.
REQ-012 Port out_valid, output, 1: payload is valid.
REQ-013 Port out_ready, input, 1: consumer accepts the payload.
REQ-014 Port done, output, 1: one-cycle completion pulse.

Function
REQ-015 The block SHALL implement four states (IDLE, RUN, FLUSH, DONE) and drive mem_addr0 directly from an internal address register at all times.
REQ-016 In IDLE with go=1, the block SHALL latch the address (start_addr >= SIZE -> 0) and remaining = min(count, SIZE).
  - Next state is DONE if the latched count is 0.
  - Otherwise, next state is RUN.
REQ-017 In RUN, a load SHALL occur on every edge where out_valid=0 or out_ready=1. A load performs all of the following:
  - out_data <= mem_read_data;
  - out_valid <= 1;
  - address <= address+1, wrapping SIZE-1 -> 0;
  - remaining <= remaining-1.
REQ-018 When a RUN load makes remaining 0, the next state SHALL be FLUSH.
REQ-019 In FLUSH, on out_ready=1 the block SHALL clear out_valid and enter DONE. No further memory words are loaded in FLUSH.
REQ-020 In DONE, done SHALL be 1 for exactly that cycle, go SHALL be ignored, and the next state SHALL be IDLE. done SHALL be 0 in every other state.
REQ-021 While out_valid=1 and out_ready=0, out_data SHALL hold stable and no load, address change or counter change SHALL occur.
REQ-022 A transfer is accepted exactly when out_valid=1 and out_ready=1 at a rising edge; each word SHALL be accepted exactly once and in address order.
REQ-023 With out_ready held at 1, throughput SHALL be one word per cycle. For go high in cycle 0 and count N>0:
  - RUN occupies cycle 1;
  - words appear in cycles 2..N+1;
  - FLUSH is cycle N+1;
  - done=1 in cycle N+2.
REQ-024 go, start_addr and count SHALL be ignored outside IDLE; changing them mid-transfer SHALL have no effect.
REQ-025 If go remains 1 after done, the block SHALL start a new transfer from IDLE on the next cycle (standard go/done semantics).

Reset
REQ-026 reset_n=0 SHALL asynchronously force the following, regardless of the current state, including mid-transfer:
  - state = IDLE;
  - out_valid = 0, out_data = 0, done = 0;
  - address register = 0, so mem_addr0 = 0;
  - remaining = 0.
REQ-027 After reset_n deasserts, the block SHALL remain in IDLE until go=1 is sampled on a rising edge.

Verification
REQ-028 Memory holds mem[i]=0x100+i, SIZE=16. Stimulus: start_addr=3, count=4, out_ready=1. Required response:
  - out_data = 0x103, 0x104, 0x105, 0x106 in cycles 2..5;
  - done=1 in cycle 6 only.
REQ-029 Wrap-around. Stimulus: start_addr=14, count=4. Required response: stream 0x10E, 0x10F, 0x100, 0x101, and mem_addr0 wraps 15 -> 0.
REQ-030 Backpressure. Stimulus: count=3, out_ready=0 for 5 cycles after the first out_valid. Required response:
  - out_data holds 0x100 and mem_addr0 is frozen during the stall;
  - all 3 words are delivered in order;
  - exactly one done pulse.
REQ-031 Boundary counts. Required responses:
  - count=0 -> out_valid never asserts, and done=1 in the cycle after go;
  - count=20 -> exactly 16 words are emitted.
REQ-032 Reset mid-transfer. Stimulus: assert reset_n=0 between clock edges while out_valid=1. Required response:
  - out_valid and out_data are 0 immediately, without waiting for a clock edge;
  - state is IDLE, and no done pulse occurs;
  - a following go transfers correctly.
REQ-033 Random out_ready, random start_addr/count, checked against a reference queue. Required response: no word is lost, duplicated or reordered; out_data is stable under stall; done pulses once per go.
